// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and the decode stage.
// master drives the fetch/decode side; slave is the queue itself.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            flush_i;
    logic [XLEN-1:0] pc_i;
    logic [31:0]     code_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] pc_o;
    logic [31:0]     code_o;
    logic            fault_o;
    logic            valid_o;
    logic            ready_i;
    logic [CntW-1:0] count_o;

    modport master (
        output flush_i, pc_i, code_i, valid_i, ready_i,
        input  ready_o, pc_o, code_o, fault_o, valid_o, count_o
    );

    modport slave (
        input  flush_i, pc_i, code_i, valid_i, ready_i,
        output ready_o, pc_o, code_o, fault_o, valid_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Elastic FIFO of {pc, instruction word, misalignment flag} between fetch and decode.
// Optional same-cycle pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input logic         clk_i,
    input logic         arst_ni,
    fetch_queue_if.slave fq
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     code;
        logic            fault;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty, full, push, pop, bypass;
    entry_t          wr_entry, head;

    assign empty = (count_q == '0);
    // DEPTH is a power of two, so the count MSB is set only when full.
    assign full  = count_q[CntW-1];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & fq.valid_i & fq.ready_i & ~fq.flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = fq.valid_i & ~full & ~fq.flush_i & ~bypass;
    assign pop  = ~empty & fq.ready_i & ~fq.flush_i;

    assign wr_entry = '{pc: fq.pc_i, code: fq.code_i, fault: |fq.pc_i[1:0]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Empty queue presents all-zero fields so the decoder sees an INVALID command.
    always_comb begin
        head       = '0;
        fq.valid_o = 1'b0;
        if (!empty) begin
            head       = mem_q[rd_ptr_q];
            fq.valid_o = 1'b1;
        end else if (bypass) begin
            head       = wr_entry;
            fq.valid_o = 1'b1;
        end
    end

    assign fq.pc_o    = head.pc;
    assign fq.code_o  = head.code;
    assign fq.fault_o = head.fault;
    assign fq.ready_o = ~full;
    assign fq.count_o = count_q;
endmodule
